// File: rtl/masked_muxn_comar.sv
// First-order masked N:1 multiplexer: binary tree of COMAR 2:1 slices, one register stage per level.
// Optional macro MASKED_MUXN_FLUSH_EN adds a synchronous 'flush' input that clears the whole pipeline.
module masked_muxn_comar #(
  parameter  int W     = 8,
  parameter  int N     = 4,
  localparam int LOG2N = $clog2(N)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
`ifdef MASKED_MUXN_FLUSH_EN
  input  logic                  flush,
`endif
  input  logic                  in_valid,
  input  logic [2*W*N-1:0]      d_in,
  input  logic [2*LOG2N-1:0]    sel,
  input  logic [6*W*(N-1)-1:0]  r,
  output logic                  out_valid,
  output logic [2*W-1:0]        c
);

  logic clr;
`ifdef MASKED_MUXN_FLUSH_EN
  assign clr = flush;
`else
  assign clr = 1'b0;
`endif

  // Heap numbering: entries 0..N-1 are the input words, node g drives entry N+g
  // and reads entries 2g (b, even) and 2g+1 (a, odd).
  logic [2*N-2:0][2*W-1:0] vals;
  logic [LOG2N-1:0][1:0]   s_lvl;

  assign vals[N-1:0] = d_in;

  function automatic int level_of(input int g);
    int lvl;
    int base;
    lvl  = 0;
    base = 0;
    for (int l = 0; l < LOG2N; l++) begin
      if (g >= base + (N >> (l + 1))) lvl = l + 1;
      base += N >> (l + 1);
    end
    return lvl;
  endfunction

  // Inputs are refreshed with rr[4]/rr[5]; the cross-domain products are masked so
  // that the four register terms sum to x&y (rr[0..3] cancel pairwise).
  function automatic logic [3:0] comar_and(input logic x0, input logic x1,
                                           input logic y0, input logic y1,
                                           input logic [5:0] rr);
    logic xr0, xr1, yr0, yr1;
    xr0 = x0 ^ rr[4];
    xr1 = x1 ^ rr[4];
    yr0 = y0 ^ rr[5];
    yr1 = y1 ^ rr[5];
    return {(xr1 & yr1) ^ rr[0] ^ rr[1] ^ rr[2],
            (xr1 & yr0) ^ rr[2] ^ rr[3],
            (xr0 & yr1) ^ rr[1],
            (xr0 & yr0) ^ rr[0] ^ rr[3]};
  endfunction

  for (genvar l = 0; l < LOG2N; l++) begin : g_sel
    if (l == 0) begin : g_direct
      assign s_lvl[l] = {sel[LOG2N], sel[0]};
    end else begin : g_delay
      logic [1:0] sd_q [l];
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int d = 0; d < l; d++) sd_q[d] <= '0;
        end else if (clr) begin
          for (int d = 0; d < l; d++) sd_q[d] <= '0;
        end else if (en) begin
          // NOTE: non-blocking assignments make every stage sample the old value of its predecessor.
          sd_q[0] <= {sel[LOG2N+l], sel[l]};
          for (int d = 1; d < l; d++) sd_q[d] <= sd_q[d-1];
        end
      end
      assign s_lvl[l] = sd_q[l-1];
    end
  end

  for (genvar g = 0; g < N-1; g++) begin : g_node
    localparam int LVL = level_of(g);
    for (genvar i = 0; i < W; i++) begin : g_bit
      logic [5:0] rr;
      logic [3:0] ta_d, tb_d;
      logic [3:0] ta_q, tb_q;

      assign rr   = r[6*(g*W+i) +: 6];
      assign ta_d = comar_and(vals[2*g+1][i], vals[2*g+1][W+i],
                              s_lvl[LVL][0], s_lvl[LVL][1], rr);
      // NOT s inverts share0 only; share1 passes through.
      assign tb_d = comar_and(vals[2*g][i], vals[2*g][W+i],
                              ~s_lvl[LVL][0], s_lvl[LVL][1], rr);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ta_q <= '0;
          tb_q <= '0;
        end else if (clr) begin
          ta_q <= '0;
          tb_q <= '0;
        end else if (en) begin
          ta_q <= ta_d;
          tb_q <= tb_d;
        end
      end

      assign vals[N+g][i]   = ^{ta_q[1:0], tb_q[1:0]};
      assign vals[N+g][W+i] = ^{ta_q[3:2], tb_q[3:2]};
    end
  end

  logic [LOG2N-1:0] vld_d, vld_q;
  assign vld_d = (vld_q << 1) | LOG2N'(in_valid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      vld_q <= '0;
    else if (clr)    vld_q <= '0;
    else if (en)     vld_q <= vld_d;
  end

  assign out_valid = vld_q[LOG2N-1];
  assign c         = vals[2*N-2];

endmodule

// File: tb/tb_masked_muxn_comar.sv
// Self-checking bench for masked_muxn_comar: scoreboarded W=4/N=4 instance plus W=1/N=2 and W=8/N=16 corners.
module tb_masked_muxn_comar;
  localparam int W = 4;
  localparam int N = 4;
  localparam int L = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic en, in_valid, out_valid;
  logic [2*W*N-1:0]     d_in;
  logic [2*L-1:0]       sel;
  logic [6*W*(N-1)-1:0] r;
  logic [2*W-1:0]       c;

  logic en_b, in_valid_b, out_valid_b;
  logic [3:0] d_in_b;
  logic [1:0] sel_b, c_b;
  logic [5:0] r_b;

  logic en_c, in_valid_c, out_valid_c;
  logic [255:0] d_in_c;
  logic [7:0]   sel_c;
  logic [719:0] r_c;
  logic [15:0]  c_c;

`ifdef MASKED_MUXN_FLUSH_EN
  logic flush;
`endif

  masked_muxn_comar #(.W(W), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
`ifdef MASKED_MUXN_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .d_in(d_in), .sel(sel), .r(r), .out_valid(out_valid), .c(c));

  masked_muxn_comar #(.W(1), .N(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_b),
`ifdef MASKED_MUXN_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(in_valid_b), .d_in(d_in_b), .sel(sel_b), .r(r_b), .out_valid(out_valid_b), .c(c_b));

  masked_muxn_comar #(.W(8), .N(16)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_c),
`ifdef MASKED_MUXN_FLUSH_EN
    .flush(1'b0),
`endif
    .in_valid(in_valid_c), .d_in(d_in_c), .sel(sel_c), .r(r_c), .out_valid(out_valid_c), .c(c_c));

  typedef struct {
    logic [N*W-1:0] words;
    logic [L-1:0]   s;
    logic [W-1:0]   exp;
  } vec_t;

  typedef struct {
    logic [W-1:0] exp;
    int           due;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_bad = 0;
  int  ecount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic randomize_r();
    for (int i = 0; i < $bits(r); i++)   r[i]   = 1'($urandom_range(0, 1));
    for (int i = 0; i < $bits(r_b); i++) r_b[i] = 1'($urandom_range(0, 1));
    for (int i = 0; i < $bits(r_c); i++) r_c[i] = 1'($urandom_range(0, 1));
  endtask

  // One clock of the main instance: sample at the following falling edge.
  task automatic tick();
    logic           adv, pov;
    logic [2*W-1:0] pc;
    sb_t            item;
    adv = en;
    pov = out_valid;
    pc  = c;
    @(posedge clk);
    if (adv) ecount++;
    @(negedge clk);
    if (!adv) begin
      check("stall_valid", out_valid, pov);
      check("stall_c", c, pc);
    end else if (out_valid) begin
      if (sb.size() == 0) begin
        check("spurious_valid", out_valid, 0);
      end else begin
        item = sb.pop_front();
        check("latency", ecount, item.due);
        check("data", c[W-1:0] ^ c[2*W-1:W], item.exp);
      end
    end else if (sb.size() > 0 && sb[0].due <= ecount) begin
      check("missing_valid", out_valid, 1);
      void'(sb.pop_front());
    end
    randomize_r();
  endtask

  task automatic issue_m(input logic [N*W-1:0] words, input logic [L-1:0] s0,
                         input logic [L-1:0] s1, input logic [W-1:0] exp, input logic v);
    logic [W-1:0] m;
    for (int j = 0; j < N; j++) begin
      m = W'($urandom);
      d_in[2*W*j +: 2*W] = {words[W*j +: W] ^ m, m};
    end
    sel      = {s1, s0};
    in_valid = v;
    en       = 1'b1;
    if (v) sb.push_back('{exp, ecount + L});
    tick();
  endtask

  task automatic issue(input logic [N*W-1:0] words, input logic [L-1:0] s,
                       input logic [W-1:0] exp, input logic v);
    logic [L-1:0] m;
    m = L'($urandom);
    issue_m(words, m, s ^ m, exp, v);
  endtask

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [N*W-1:0] words;
    logic [L-1:0]   s;
    logic [1:0]     wb;
    logic           mb;
    logic [127:0]   wc;
    logic [7:0]     mc8;
    logic [3:0]     mc;

    tbl[0] = '{16'hC5A3, 2'd0, 4'h3};
    tbl[1] = '{16'hC5A3, 2'd1, 4'hA};
    tbl[2] = '{16'hC5A3, 2'd2, 4'h5};
    tbl[3] = '{16'hC5A3, 2'd3, 4'hC};
    tbl[4] = '{16'h0F96, 2'd3, 4'h0};
    tbl[5] = '{16'h0F96, 2'd2, 4'hF};
    tbl[6] = '{16'h0F96, 2'd1, 4'h9};
    tbl[7] = '{16'h0F96, 2'd0, 4'h6};

    rst_n = 1'b0;
    en = 1'b0; in_valid = 1'b0; d_in = '0; sel = '0; r = '0;
    en_b = 1'b0; in_valid_b = 1'b0; d_in_b = '0; sel_b = '0; r_b = '0;
    en_c = 1'b0; in_valid_c = 1'b0; d_in_c = '0; sel_c = '0; r_c = '0;
`ifdef MASKED_MUXN_FLUSH_EN
    flush = 1'b0;
`endif
    #1;
    check("reset_valid", out_valid, 0);
    check("reset_c", c, 0);
    check("reset_valid_b", out_valid_b, 0);
    check("reset_valid_c", out_valid_c, 0);
    check("reset_c_c", c_c, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // sel=2 carried as shares (1,3)
    issue_m(16'hC5A3, 2'd1, 2'd3, 4'h5, 1'b1);
    // Back-to-back table items
    foreach (tbl[i]) issue(tbl[i].words, tbl[i].s, tbl[i].exp, 1'b1);
    repeat (L) issue('0, '0, '0, 1'b0);

    for (int k = 0; k < 1000; k++) begin
      words = 16'($urandom);
      s     = 2'($urandom);
      issue(words, s, words[s*W +: W], ($urandom_range(0, 7) != 0));
    end
    repeat (L) issue('0, '0, '0, 1'b0);

    // Stall with an item in level 0, then with a result sitting on the output
    issue(16'hC5A3, 2'd3, 4'hC, 1'b1);
    en = 1'b0; in_valid = 1'b1;
    repeat (5) tick();
    en = 1'b1; in_valid = 1'b0;
    tick();
    check("stall_result_valid", out_valid, 1);
    en = 1'b0;
    repeat (3) tick();
    check("stall_hold_data", c[W-1:0] ^ c[2*W-1:W], 4'hC);
    repeat (L) issue('0, '0, '0, 1'b0);
    check("drained_1", sb.size(), 0);

    // Asynchronous reset with two items in flight
    issue(16'hC5A3, 2'd1, 4'hA, 1'b1);
    issue(16'hC5A3, 2'd3, 4'hC, 1'b1);
    en = 1'b1; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("midreset_valid", out_valid, 0);
    check("midreset_c", c, 0);
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("post_reset_valid", out_valid, 0);
    end

    // Corner W=1, N=2: latency 1
    en = 1'b0; in_valid = 1'b0;
    en_b = 1'b1;
    for (int sv = 0; sv < 2; sv++) begin
      for (int rep = 0; rep < 4; rep++) begin
        wb = 2'($urandom);
        for (int j = 0; j < 2; j++) begin
          mb = 1'($urandom);
          d_in_b[2*j +: 2] = {wb[j] ^ mb, mb};
        end
        mb = 1'($urandom);
        sel_b = {1'(sv) ^ mb, mb};
        in_valid_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        randomize_r();
        in_valid_b = 1'b0;
        check("b_valid", out_valid_b, 1);
        check("b_data", c_b[0] ^ c_b[1], wb[sv]);
      end
    end
    en_b = 1'b0;

    // Corner W=8, N=16: latency 4
    en_c = 1'b1;
    for (int sv = 0; sv < 16; sv++) begin
      for (int q = 0; q < 4; q++) wc[32*q +: 32] = $urandom;
      for (int j = 0; j < 16; j++) begin
        mc8 = 8'($urandom);
        d_in_c[16*j +: 16] = {wc[8*j +: 8] ^ mc8, mc8};
      end
      mc = 4'($urandom);
      sel_c = {4'(sv) ^ mc, mc};
      in_valid_c = 1'b1;
      for (int k = 1; k <= 4; k++) begin
        @(posedge clk);
        @(negedge clk);
        randomize_r();
        in_valid_c = 1'b0;
        if (k < 4) check("c_early_valid", out_valid_c, 0);
      end
      check("c_valid", out_valid_c, 1);
      check("c_data", c_c[7:0] ^ c_c[15:8], wc[8*sv +: 8]);
    end
    en_c = 1'b0;

`ifdef MASKED_MUXN_FLUSH_EN
    issue(16'hC5A3, 2'd0, 4'h3, 1'b1);
    issue(16'hC5A3, 2'd1, 4'hA, 1'b1);
    issue(16'hC5A3, 2'd2, 4'h5, 1'b1);
    sb.delete();
    en = 1'b1; in_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", out_valid, 0);
    check("flush_c", c, 0);
    for (int k = 0; k < L; k++) begin
      tick();
      check("post_flush_valid", out_valid, 0);
    end
    issue(16'hC5A3, 2'd3, 4'hC, 1'b1);
    repeat (L) issue('0, '0, '0, 1'b0);
`endif
    check("drained_end", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
